mem_access_responder: RTL and testbench

MEM_ACCESS_RESPONDER -- requirements
Module: mem_access_responder

---
 rtl/mem_access_responder_pkg.sv | 29 ++
 rtl/mem_access_responder_if.sv | 43 ++++
 rtl/rd_byte_pack.sv | 70 +++++++
 rtl/mem_access_responder.sv | 155 +++++++++++++++
 tb/tb_mem_access_responder.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_responder_pkg
// Description : Shared types and constants for the memory access responder:
//               FSM state encoding, reset instruction word and the number of
//               bytes in one memory word.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_DACC   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // ADDI x0,x0,0 -- what the sequencer sees before the first fetch completes.
  localparam logic [31:0] c_NOP_INST       = 32'h0000_0013;
  localparam int          c_BYTES_PER_WORD = 4;
  localparam logic [1:0]  c_LAST_LANE      = 2'(c_BYTES_PER_WORD - 1);

  // Little-endian byte select from a 32-bit word.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_responder_if
// Description : Bundles the sequencer-side request/response signals and the
//               byte-wide external memory port of the access responder.
//               slave  : responder view (requests and mem_rdata in).
//               master : sequencer + memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_responder_if;

  // Sequencer side
  logic        cpu_stat_imr;
  logic        cpu_stat_dmrw;
  logic [13:0] pc;
  logic [15:0] dm_addr;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        imr_run;
  logic        dmrw_run;
  logic [31:0] inst;
  logic [31:0] dm_rdata;

  // External byte-wide memory side
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_stat_imr, cpu_stat_dmrw, pc, dm_addr, dm_we, dm_be, dm_wdata, mem_rdata,
    output imr_run, dmrw_run, inst, dm_rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output cpu_stat_imr, cpu_stat_dmrw, pc, dm_addr, dm_we, dm_be, dm_wdata, mem_rdata,
    input  imr_run, dmrw_run, inst, dm_rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/rd_byte_pack.sv
`default_nettype none
// ============================================================================
// Module      : rd_byte_pack
// Description : Tracks read strobes through the external memory latency and
//               assembles the returning bytes into a 4-lane word.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_flush         - drop everything in flight (aborted access)
//               i_valid, i_lane - read strobe issued this cycle and its lane
//               i_mem_rdata     - byte returned by the external memory
//               o_word_done     - last lane arrives this cycle
//               o_word          - assembled word including this cycle's byte
// Revision    : 1.0 - initial release
// ============================================================================
module rd_byte_pack
  import mem_access_responder_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        i_flush,
  input  wire logic        i_valid,
  input  wire logic [1:0]  i_lane,
  input  wire logic [7:0]  i_mem_rdata,
  output logic             o_word_done,
  output logic [31:0]      o_word
);

  // Stage RD_LAT-1 lines up with the cycle in which the memory presents the byte.
  logic [RD_LAT-1:0] r_vld;
  logic [1:0]        r_lane_idx [RD_LAT];
  logic [7:0]        r_lane     [c_BYTES_PER_WORD];
  logic [7:0]        w_lane     [c_BYTES_PER_WORD];

  // Merge the arriving byte so the word is complete at the same edge the
  // last lane is registered.
  always_comb begin
    for (int i = 0; i < c_BYTES_PER_WORD; i++) begin
      w_lane[i] = r_lane[i];
    end
    if (r_vld[RD_LAT-1]) begin
      w_lane[r_lane_idx[RD_LAT-1]] = i_mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_lane_idx[i] <= '0;
      for (int i = 0; i < c_BYTES_PER_WORD; i++) r_lane[i] <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_lane_idx[i] <= '0;
      for (int i = 0; i < c_BYTES_PER_WORD; i++) r_lane[i] <= '0;
    end else begin
      r_vld[0]      <= i_valid;
      r_lane_idx[0] <= i_lane;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]      <= r_vld[i-1];
        r_lane_idx[i] <= r_lane_idx[i-1];
      end
      for (int i = 0; i < c_BYTES_PER_WORD; i++) r_lane[i] <= w_lane[i];
    end
  end

  assign o_word_done = r_vld[RD_LAT-1] && (r_lane_idx[RD_LAT-1] == c_LAST_LANE);
  assign o_word      = {w_lane[3], w_lane[2], w_lane[1], w_lane[0]};

endmodule
`default_nettype wire

// File: rtl/mem_access_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_responder
// Description : Serves instruction fetches and data loads/stores from the
//               sequencer over a byte-wide external memory, one byte per
//               cycle, four bytes per word.
// Ports       : clk, rst_n - clock, async active-low reset
//               bus (slave) - sequencer requests/responses and external
//                             memory strobes (see mem_access_responder_if)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_responder
  import mem_access_responder_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  mem_access_responder_if.slave bus
);

  state_t      r_state;
  logic        r_is_fetch;
  logic        r_is_store;
  logic        r_issue;      // still walking bytes 0..3 out on the memory port
  logic [1:0]  r_cnt;        // byte index currently on the memory port
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_inst;
  logic [31:0] r_rdata;
  logic [15:0] r_mem_addr;
  logic        r_mem_re;
  logic        r_mem_we;
  logic [7:0]  r_mem_wdata;

  logic        w_busy;
  logic        w_active_req;
  logic        w_abort;
  logic [1:0]  w_cnt_next;
  logic        w_word_done;
  logic [31:0] w_word;

  assign w_busy       = (r_state == ST_IFETCH) || (r_state == ST_DACC);
  // The request that started the access is the one that can abort or release it.
  assign w_active_req = r_is_fetch ? bus.cpu_stat_imr : bus.cpu_stat_dmrw;
  assign w_abort      = w_busy && !w_active_req;
  assign w_cnt_next   = r_cnt + 2'd1;

  rd_byte_pack #(
    .RD_LAT (RD_LAT)
  ) u_rd_byte_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (w_abort),
    .i_valid     (r_mem_re),
    .i_lane      (r_cnt),
    .i_mem_rdata (bus.mem_rdata),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_is_fetch  <= 1'b0;
      r_is_store  <= 1'b0;
      r_issue     <= 1'b0;
      r_cnt       <= 2'd0;
      r_be        <= 4'h0;
      r_wdata     <= 32'h0;
      r_inst      <= c_NOP_INST;
      r_rdata     <= 32'h0;
      r_mem_addr  <= 16'h0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cpu_stat_dmrw) begin
            r_state     <= ST_DACC;
            r_is_fetch  <= 1'b0;
            r_is_store  <= bus.dm_we;
            r_be        <= bus.dm_be;
            r_wdata     <= bus.dm_wdata;
            r_issue     <= 1'b1;
            r_cnt       <= 2'd0;
            r_mem_addr  <= bus.dm_addr & 16'hFFFC;
            r_mem_re    <= !bus.dm_we;
            r_mem_we    <= bus.dm_we && bus.dm_be[0];
            r_mem_wdata <= bus.dm_we ? byte_of(bus.dm_wdata, 2'd0) : 8'h00;
          end else if (bus.cpu_stat_imr) begin
            r_state     <= ST_IFETCH;
            r_is_fetch  <= 1'b1;
            r_is_store  <= 1'b0;
            r_issue     <= 1'b1;
            r_cnt       <= 2'd0;
            r_mem_addr  <= {bus.pc, 2'b00};
            r_mem_re    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h00;
          end
        end

        ST_IFETCH, ST_DACC: begin
          if (w_abort) begin
            r_state     <= ST_IDLE;
            r_issue     <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h00;
          end else begin
            if (r_issue) begin
              if (r_cnt == c_LAST_LANE) begin
                r_issue     <= 1'b0;
                r_mem_re    <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_wdata <= 8'h00;
                // Stores have nothing coming back, so they finish with the last byte.
                if (r_is_store) r_state <= ST_DONE;
              end else begin
                r_cnt       <= w_cnt_next;
                // Only the low bits walk, keeping every byte inside the word.
                r_mem_addr  <= {r_mem_addr[15:2], w_cnt_next};
                r_mem_re    <= !r_is_store;
                r_mem_we    <= r_is_store && r_be[w_cnt_next];
                r_mem_wdata <= r_is_store ? byte_of(r_wdata, w_cnt_next) : 8'h00;
              end
            end
            if (!r_is_store && w_word_done) begin
              r_state <= ST_DONE;
              if (r_is_fetch) r_inst  <= w_word;
              else            r_rdata <= w_word;
            end
          end
        end

        ST_DONE: begin
          if (!w_active_req) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.imr_run   = bus.cpu_stat_imr  && (r_state != ST_DONE);
  assign bus.dmrw_run  = bus.cpu_stat_dmrw && (r_state != ST_DONE);
  assign bus.inst      = r_inst;
  assign bus.dm_rdata  = r_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_responder
// Description : Drives two responders (read latency 1 and 3) with identical
//               sequencer traffic; each has its own byte-wide memory model.
//               Expected strobes, run flags and returned words come from a
//               cycle-numbered model of the access protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_responder_if bus1 ();
  mem_access_responder_if bus3 ();

  mem_access_responder #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_access_responder #(.RD_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:65535];
  int          lat_of [2] = '{1, 3};
  logic [31:0] exp_inst  [2];
  logic [31:0] exp_rdata [2];

  logic        s_re [2], s_we [2], s_irun [2], s_drun [2];
  logic [15:0] s_addr [2];
  logic [7:0]  s_wd [2];
  logic [31:0] s_inst [2], s_rdata [2];

  // ---------------- memory models ----------------
  logic        c1_re;
  logic [15:0] c1_addr;
  initial begin
    bus1.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      c1_re = bus1.mem_re; c1_addr = bus1.mem_addr;
      @(posedge clk); #1;
      bus1.mem_rdata = c1_re ? mem[c1_addr] : 8'($urandom);
    end
  end

  logic        p3_re [3];
  logic [15:0] p3_addr [3];
  logic        n3_re;
  logic [15:0] n3_addr;
  initial begin
    bus3.mem_rdata = 8'h00;
    for (int i = 0; i < 3; i++) begin p3_re[i] = 1'b0; p3_addr[i] = 16'h0; end
    forever begin
      @(negedge clk);
      n3_re = bus3.mem_re; n3_addr = bus3.mem_addr;
      @(posedge clk); #1;
      p3_re[2] = p3_re[1]; p3_addr[2] = p3_addr[1];
      p3_re[1] = p3_re[0]; p3_addr[1] = p3_addr[0];
      p3_re[0] = n3_re;    p3_addr[0] = n3_addr;
      bus3.mem_rdata = p3_re[2] ? mem[p3_addr[2]] : 8'($urandom);
    end
  end

  // ---------------- utilities (no comparisons) ----------------
  task automatic sample();
    s_re[0] = bus1.mem_re;   s_re[1] = bus3.mem_re;
    s_we[0] = bus1.mem_we;   s_we[1] = bus3.mem_we;
    s_irun[0] = bus1.imr_run;  s_irun[1] = bus3.imr_run;
    s_drun[0] = bus1.dmrw_run; s_drun[1] = bus3.dmrw_run;
    s_addr[0] = bus1.mem_addr;  s_addr[1] = bus3.mem_addr;
    s_wd[0] = bus1.mem_wdata;   s_wd[1] = bus3.mem_wdata;
    s_inst[0] = bus1.inst;      s_inst[1] = bus3.inst;
    s_rdata[0] = bus1.dm_rdata; s_rdata[1] = bus3.dm_rdata;
  endtask

  task automatic drive(input bit imr, input bit dmrw, input logic [13:0] pc_v,
                       input logic [15:0] addr_v, input bit we, input logic [3:0] be,
                       input logic [31:0] wd);
    bus1.cpu_stat_imr = imr;  bus3.cpu_stat_imr = imr;
    bus1.cpu_stat_dmrw = dmrw; bus3.cpu_stat_dmrw = dmrw;
    bus1.pc = pc_v;       bus3.pc = pc_v;
    bus1.dm_addr = addr_v; bus3.dm_addr = addr_v;
    bus1.dm_we = we;      bus3.dm_we = we;
    bus1.dm_be = be;      bus3.dm_be = be;
    bus1.dm_wdata = wd;   bus3.dm_wdata = wd;
  endtask

  task automatic set_word(input logic [15:0] base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[base + 16'(i)] = w[8*i +: 8];
  endtask

  // One access, cycle-numbered from the request cycle T0. abort_at >= 0 drops
  // the request in that cycle; otherwise it is held `hold` cycles past the
  // slower responder's DONE.
  task automatic run_access(input string name, input bit imr, input bit dmrw,
                            input logic [13:0] pc_v, input logic [15:0] addr_v,
                            input bit we, input logic [3:0] be, input logic [31:0] wd,
                            input int abort_at, input int hold);
    bit fetch, store, req, strobe, in_done;
    bit e_re, e_we, e_irun, e_drun;
    logic [15:0] base, e_addr;
    logic [7:0]  e_wd;
    logic [31:0] word;
    int done_t [2];
    bit aborted [2];
    int t_drop, k;
    fetch = !dmrw;
    store = dmrw && we;
    base  = fetch ? {pc_v, 2'b00} : (addr_v & 16'hFFFC);
    for (int d = 0; d < 2; d++) done_t[d] = store ? 5 : 5 + lat_of[d];
    t_drop = (abort_at >= 0) ? abort_at : done_t[1] + hold;
    for (int d = 0; d < 2; d++) aborted[d] = (t_drop < done_t[d]);
    @(posedge clk); #1;
    for (int t = 0; t <= t_drop + 2; t++) begin
      req = (t < t_drop);
      drive(req && imr, req && dmrw, pc_v, addr_v, we, be, wd);
      @(negedge clk);
      sample();
      k = t - 1;
      strobe = (t >= 1) && (t <= 4) && (t <= t_drop);
      e_re = strobe && !store;
      e_we = 1'b0; e_wd = 8'h00; e_addr = 16'h0;
      if (strobe) begin
        e_we   = store && be[k];
        e_wd   = wd[8*k +: 8];
        e_addr = base + 16'(k);
      end
      for (int d = 0; d < 2; d++) begin
        in_done = !aborted[d] && (t >= done_t[d]);
        e_irun = req && imr && !in_done;
        e_drun = req && dmrw && !in_done;
        checks++;
        if ({s_re[d], s_we[d], s_irun[d], s_drun[d]} !== {e_re, e_we, e_irun, e_drun}) begin
          errors++;
          $display("FAIL %s t=%0d lat=%0d re/we/imr_run/dmrw_run got=%b%b%b%b want=%b%b%b%b",
                   name, t, lat_of[d], s_re[d], s_we[d], s_irun[d], s_drun[d],
                   e_re, e_we, e_irun, e_drun);
        end
        if (strobe) begin
          checks++;
          if (s_addr[d] !== e_addr) begin
            errors++;
            $display("FAIL %s t=%0d lat=%0d mem_addr got=%h want=%h", name, t, lat_of[d], s_addr[d], e_addr);
          end
          if (store) begin
            checks++;
            if (s_wd[d] !== e_wd) begin
              errors++;
              $display("FAIL %s t=%0d lat=%0d mem_wdata got=%h want=%h", name, t, lat_of[d], s_wd[d], e_wd);
            end
          end
        end
      end
      @(posedge clk); #1;
    end
    word = {mem[base + 16'd3], mem[base + 16'd2], mem[base + 16'd1], mem[base]};
    sample();
    for (int d = 0; d < 2; d++) begin
      if (!aborted[d] && !store) begin
        if (fetch) exp_inst[d] = word;
        else       exp_rdata[d] = word;
      end
      checks++;
      if (s_inst[d] !== exp_inst[d] || s_rdata[d] !== exp_rdata[d]) begin
        errors++;
        $display("FAIL %s lat=%0d inst/dm_rdata got=%h/%h want=%h/%h",
                 name, lat_of[d], s_inst[d], s_rdata[d], exp_inst[d], exp_rdata[d]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (s_inst[d] !== NOP || s_rdata[d] !== 32'h0 || s_re[d] !== 1'b0 || s_we[d] !== 1'b0 ||
          s_addr[d] !== 16'h0 || s_wd[d] !== 8'h0 || s_irun[d] !== 1'b0 || s_drun[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset lat=%0d inst=%h rdata=%h re=%b we=%b addr=%h wd=%h want %h/0/0/0/0/0",
                 lat_of[d], s_inst[d], s_rdata[d], s_re[d], s_we[d], s_addr[d], s_wd[d], NOP);
      end
      exp_inst[d] = NOP; exp_rdata[d] = 32'h0;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_abort();
    set_word(16'h0080, 32'h1234_5678);
    run_access("abort_fetch", 1'b1, 1'b0, 14'h0020, 16'h0, 1'b0, 4'h0, 32'h0, 2, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (s_inst[d] !== NOP) begin
        errors++;
        $display("FAIL abort_inst lat=%0d got=%h want=%h", lat_of[d], s_inst[d], NOP);
      end
    end
  endtask

  task automatic test_fetch();
    set_word(16'h0040, 32'h0000_0513);
    run_access("fetch", 1'b1, 1'b0, 14'h0010, 16'h0, 1'b0, 4'h0, 32'h0, -1, 1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (s_inst[d] !== 32'h0000_0513) begin
        errors++;
        $display("FAIL fetch_word lat=%0d got=%h want=00000513", lat_of[d], s_inst[d]);
      end
    end
  endtask

  task automatic test_load();
    set_word(16'h0100, 32'hDEAD_BEEF);
    run_access("load", 1'b0, 1'b1, 14'h0, 16'h0102, 1'b0, 4'h0, 32'h0, -1, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (s_rdata[d] !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL load_word lat=%0d got=%h want=deadbeef", lat_of[d], s_rdata[d]);
      end
    end
  endtask

  task automatic test_store();
    run_access("store_be5", 1'b0, 1'b1, 14'h0, 16'h0200, 1'b1, 4'b0101, 32'hAABB_CCDD, -1, 2);
    run_access("store_be0", 1'b0, 1'b1, 14'h0, 16'h0304, 1'b1, 4'b0000, 32'h1122_3344, -1, 0);
  endtask

  task automatic test_priority();
    set_word(16'h0A00, 32'hCAFE_F00D);
    set_word(16'h0500, 32'h0BAD_0BAD);
    run_access("priority", 1'b1, 1'b1, 14'h0140, 16'h0A03, 1'b0, 4'h0, 32'h0, -1, 1);
    set_word(16'hFFFC, 32'h8899_AABB);
    run_access("top_word", 1'b0, 1'b1, 14'h0, 16'hFFFF, 1'b0, 4'h0, 32'h0, -1, 0);
  endtask

  task automatic test_random();
    int kind, abort_at;
    logic [13:0] pc_v;
    logic [15:0] addr_v;
    for (int i = 0; i < 30; i++) begin
      kind     = $urandom_range(0, 2);
      pc_v     = 14'($urandom);
      addr_v   = 16'($urandom);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -1;
      set_word({pc_v, 2'b00}, $urandom);
      set_word(addr_v & 16'hFFFC, $urandom);
      run_access("random", (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1)), kind != 0,
                 pc_v, addr_v, kind == 2, 4'($urandom), $urandom, abort_at, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    set_word(16'h0600, 32'h5566_7788);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 14'h0010, 16'h0600, 1'b0, 4'hF, 32'h0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      sample();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (t > 0 && (s_re[d] !== 1'b1 || s_addr[d] !== 16'h0600 + 16'(t - 1))) begin
          errors++;
          $display("FAIL rst_mid_pre t=%0d lat=%0d re=%b addr=%h want 1/%h",
                   t, lat_of[d], s_re[d], s_addr[d], 16'h0600 + 16'(t - 1));
        end
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 4'h0, 32'h0);
    #2;
    sample();
    for (int d = 0; d < 2; d++) begin
      exp_inst[d] = NOP; exp_rdata[d] = 32'h0;
      checks++;
      if (s_inst[d] !== NOP || s_rdata[d] !== 32'h0 || s_re[d] !== 1'b0 || s_we[d] !== 1'b0 ||
          s_addr[d] !== 16'h0 || s_wd[d] !== 8'h0 || s_irun[d] !== 1'b0 || s_drun[d] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid lat=%0d inst=%h rdata=%h re=%b we=%b addr=%h wd=%h want %h/0/0/0/0/0",
                 lat_of[d], s_inst[d], s_rdata[d], s_re[d], s_we[d], s_addr[d], s_wd[d], NOP);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      sample();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (s_re[d] !== 1'b0 || s_we[d] !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_quiet t=%0d lat=%0d re=%b we=%b want 0/0", t, lat_of[d], s_re[d], s_we[d]);
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 4'h0, 32'h0);
    test_reset();
    test_abort();
    test_fetch();
    test_load();
    test_store();
    test_priority();
    test_random();
    test_reset_mid();
    set_word(16'h0044, 32'h00A0_0093);
    run_access("after_reset", 1'b1, 1'b0, 14'h0011, 16'h0, 1'b0, 4'h0, 32'h0, -1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
